// File: rtl/chan_512_cfg_pkg.sv
// chan_512_cfg_pkg: register map, CTRL bit positions and sequencer state type
// shared by the OPB interface and the table fill sequencer.
package chan_512_cfg_pkg;

  localparam int unsigned TBL_AW_DEF = 9;
  localparam int unsigned NUM_REGS   = 6;

  localparam logic [7:0] OFF_CTRL     = 8'h00;
  localparam logic [7:0] OFF_START    = 8'h04;
  localparam logic [7:0] OFF_COUNT    = 8'h08;
  localparam logic [7:0] OFF_VALUE    = 8'h0C;
  localparam logic [7:0] OFF_STEP     = 8'h10;
  localparam logic [7:0] OFF_PROGRESS = 8'h14;

  // CTRL write bits
  localparam int unsigned CTRL_GO       = 0;
  localparam int unsigned CTRL_ABORT    = 1;
  localparam int unsigned CTRL_CLR      = 2;
  localparam int unsigned CTRL_IRQ_MASK = 4;

  // CTRL read bits
  localparam int unsigned STAT_BUSY = 0;
  localparam int unsigned STAT_DONE = 1;
  localparam int unsigned STAT_ERR  = 2;
  localparam int unsigned STAT_ABT  = 3;

  typedef enum logic {S_IDLE, S_WRITE} seq_state_e;

  // be[i] enables bits [8i+7:8i]
  function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                           input logic [31:0] new_v,
                                           input logic [3:0]  be);
    logic [31:0] r;
    r = old_v;
    for (int unsigned i = 0; i < 4; i++)
      if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
    return r;
  endfunction

endpackage

// File: rtl/chan_512_cfg_opb_if.sv
// chan_512_cfg_opb_if: OPB slave decode with registered hit, single-cycle ack,
// write strobes for the register bank and the read-data mux.
module chan_512_cfg_opb_if
  import chan_512_cfg_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR   = 32'h010C0000,
  parameter logic [31:0] C_HIGHADDR   = 32'h010C00FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32
) (
  input  logic                                     OPB_Clk,
  input  logic                                     OPB_Rst,
  input  logic [0:C_OPB_AWIDTH-1]                  OPB_ABus,
  input  logic [0:C_OPB_DWIDTH/8-1]                OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1]                  OPB_DBus,
  input  logic                                     OPB_RNW,
  input  logic                                     OPB_select,
  input  logic [NUM_REGS-1:0][C_OPB_DWIDTH-1:0]    rd_regs,
  output logic [0:C_OPB_DWIDTH-1]                  Sl_DBus,
  output logic                                     Sl_xferAck,
  output logic                                     wr_stb,
  output logic [7:0]                               wr_off,
  output logic [C_OPB_DWIDTH-1:0]                  wr_data,
  output logic [C_OPB_DWIDTH/8-1:0]                wr_be
);

  logic [C_OPB_AWIDTH-1:0]   addr;
  logic [C_OPB_DWIDTH-1:0]   wdata;
  logic [C_OPB_DWIDTH/8-1:0] be_le;
  logic [7:0]                off;
  logic                      hit, in_xfer, ack_q, rnw_q;
  logic [7:0]                off_q;
  logic [C_OPB_DWIDTH-1:0]   data_q, rdata;
  logic [C_OPB_DWIDTH/8-1:0] be_q;

  // Big-endian buses map positionally: OPB_BE[0] lands on be_le[MSB].
  assign addr  = OPB_ABus;
  assign wdata = OPB_DBus;
  assign be_le = OPB_BE;
  assign off   = addr[7:0] - C_BASEADDR[7:0];
  assign hit   = OPB_select && (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);

  // in_xfer holds off re-acking until the master drops select.
  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      in_xfer <= 1'b0;
      ack_q   <= 1'b0;
      rnw_q   <= 1'b0;
      off_q   <= '0;
      data_q  <= '0;
      be_q    <= '0;
    end else begin
      ack_q   <= hit && !in_xfer;
      in_xfer <= OPB_select && (in_xfer || hit);
      if (hit && !in_xfer) begin
        rnw_q  <= OPB_RNW;
        off_q  <= off;
        data_q <= wdata;
        be_q   <= be_le;
      end
    end
  end

  always_comb begin
    rdata = '0;
    if (off_q[1:0] == 2'b00 && 32'(off_q[7:2]) < NUM_REGS)
      rdata = rd_regs[off_q[4:2]];
  end

  assign Sl_xferAck = ack_q;
  assign Sl_DBus    = (ack_q && rnw_q) ? rdata : '0;
  assign wr_stb     = ack_q && !rnw_q;
  assign wr_off     = off_q;
  assign wr_data    = data_q;
  assign wr_be      = be_q;

endmodule

// File: rtl/chan_512_cfg_seq.sv
// chan_512_cfg_seq: OPB-programmed fill sequencer for the channelizer config table.
// Optional CHAN_CFG_SEQ_IRQ_EN adds an irq pulse on DONE/ABT rise with a CTRL mask bit.
module chan_512_cfg_seq
  import chan_512_cfg_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR   = 32'h010C0000,
  parameter logic [31:0] C_HIGHADDR   = 32'h010C00FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter int unsigned TBL_AW       = TBL_AW_DEF
) (
  input  logic                     OPB_Clk,
  input  logic                     OPB_Rst,
  input  logic [0:C_OPB_AWIDTH-1]  OPB_ABus,
  input  logic [0:C_OPB_DWIDTH/8-1] OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1]  OPB_DBus,
  input  logic                     OPB_RNW,
  input  logic                     OPB_select,
  input  logic                     OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1]  Sl_DBus,
  output logic                     Sl_xferAck,
  output logic                     Sl_errAck,
  output logic                     Sl_retry,
  output logic                     Sl_toutSup,
  output logic [TBL_AW-1:0]        tbl_addr,
  output logic [31:0]              tbl_data,
  output logic                     tbl_we,
  input  logic                     tbl_ready,
`ifdef CHAN_CFG_SEQ_IRQ_EN
  output logic                     irq,
`endif
  output logic                     busy
);

  localparam logic [TBL_AW:0] DEPTH = {1'b1, {TBL_AW{1'b0}}};

  logic                       wr_stb;
  logic [7:0]                 wr_off;
  logic [31:0]                wr_data;
  logic [3:0]                 wr_be;
  logic [NUM_REGS-1:0][31:0]  rd_regs;
  logic [31:0]                ctrl_rd;

  logic [TBL_AW-1:0] start_r;
  logic [TBL_AW:0]   count_r, count_eff, rem_r, progress_r;
  logic [31:0]       value_r, step_r, step_lat;
  logic              done_r, err_r, abt_r, irq_mask_r;
  logic              wr_ctrl, go, abort, clr, accept, unused_seq;
  seq_state_e        state;

  assign unused_seq = OPB_seqAddr;
  assign Sl_errAck  = 1'b0;
  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = 1'b0;

  chan_512_cfg_opb_if #(
    .C_BASEADDR  (C_BASEADDR),
    .C_HIGHADDR  (C_HIGHADDR),
    .C_OPB_AWIDTH(C_OPB_AWIDTH),
    .C_OPB_DWIDTH(C_OPB_DWIDTH)
  ) u_opb_if (
    .OPB_Clk   (OPB_Clk),
    .OPB_Rst   (OPB_Rst),
    .OPB_ABus  (OPB_ABus),
    .OPB_BE    (OPB_BE),
    .OPB_DBus  (OPB_DBus),
    .OPB_RNW   (OPB_RNW),
    .OPB_select(OPB_select),
    .rd_regs   (rd_regs),
    .Sl_DBus   (Sl_DBus),
    .Sl_xferAck(Sl_xferAck),
    .wr_stb    (wr_stb),
    .wr_off    (wr_off),
    .wr_data   (wr_data),
    .wr_be     (wr_be)
  );

  assign wr_ctrl   = wr_stb && (wr_off == OFF_CTRL) && wr_be[0];
  assign go        = wr_ctrl && wr_data[CTRL_GO];
  assign abort     = wr_ctrl && wr_data[CTRL_ABORT];
  assign clr       = wr_ctrl && wr_data[CTRL_CLR];
  assign accept    = tbl_we && tbl_ready;
  assign busy      = (state == S_WRITE);
  assign count_eff = (count_r > DEPTH) ? DEPTH : count_r;

  always_comb begin
    ctrl_rd                = '0;
    ctrl_rd[STAT_BUSY]     = busy;
    ctrl_rd[STAT_DONE]     = done_r;
    ctrl_rd[STAT_ERR]      = err_r;
    ctrl_rd[STAT_ABT]      = abt_r;
    ctrl_rd[CTRL_IRQ_MASK] = irq_mask_r;
  end

  assign rd_regs[0] = ctrl_rd;
  assign rd_regs[1] = 32'(start_r);
  assign rd_regs[2] = 32'(count_r);
  assign rd_regs[3] = value_r;
  assign rd_regs[4] = step_r;
  assign rd_regs[5] = 32'(progress_r);

  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      start_r <= '0;
      count_r <= '0;
      value_r <= '0;
      step_r  <= '0;
    end else if (wr_stb) begin
      case (wr_off)
        OFF_START: start_r <= TBL_AW'(be_merge(32'(start_r), wr_data, wr_be));
        OFF_COUNT: count_r <= (TBL_AW+1)'(be_merge(32'(count_r), wr_data, wr_be));
        OFF_VALUE: value_r <= be_merge(value_r, wr_data, wr_be);
        OFF_STEP:  step_r  <= be_merge(step_r, wr_data, wr_be);
        default:   ;
      endcase
    end
  end

  // Run parameters are latched at GO so config writes during a run only shadow.
  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      state      <= S_IDLE;
      tbl_we     <= 1'b0;
      tbl_addr   <= '0;
      tbl_data   <= '0;
      step_lat   <= '0;
      rem_r      <= '0;
      progress_r <= '0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
      abt_r      <= 1'b0;
    end else begin
      if (clr) begin
        done_r <= 1'b0;
        err_r  <= 1'b0;
        abt_r  <= 1'b0;
      end
      case (state)
        S_IDLE: begin
          if (go && !abort) begin
            if (count_r == '0) begin
              done_r <= 1'b1;
            end else begin
              state      <= S_WRITE;
              tbl_we     <= 1'b1;
              tbl_addr   <= start_r;
              tbl_data   <= value_r;
              step_lat   <= step_r;
              rem_r      <= count_eff;
              progress_r <= '0;
              done_r     <= 1'b0;
            end
          end
        end
        S_WRITE: begin
          if (go && !abort) err_r <= 1'b1;
          if (accept) begin
            tbl_addr   <= tbl_addr + 1'b1;
            tbl_data   <= tbl_data + step_lat;
            rem_r      <= rem_r - 1'b1;
            progress_r <= progress_r + 1'b1;
          end
          if (abort) begin
            state  <= S_IDLE;
            tbl_we <= 1'b0;
            abt_r  <= 1'b1;
          end else if (accept && rem_r == (TBL_AW+1)'(1)) begin
            state  <= S_IDLE;
            tbl_we <= 1'b0;
            done_r <= 1'b1;
          end
        end
      endcase
    end
  end

`ifdef CHAN_CFG_SEQ_IRQ_EN
  logic done_d, abt_d;

  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      irq_mask_r <= 1'b0;
      done_d     <= 1'b0;
      abt_d      <= 1'b0;
      irq        <= 1'b0;
    end else begin
      if (wr_ctrl) irq_mask_r <= wr_data[CTRL_IRQ_MASK];
      done_d <= done_r;
      abt_d  <= abt_r;
      irq    <= !irq_mask_r && ((done_r && !done_d) || (abt_r && !abt_d));
    end
  end
`else
  assign irq_mask_r = 1'b0;
`endif

endmodule
